nbody_sequencer: RTL and testbench
==================================

NBODY_SEQUENCER -- requirements
Module: nbody_sequencer

Interface
REQ-001 SHALL have parameter BODIES, default 512, meaning the maximum body count and memory depth.
REQ-002 SHALL have parameter ACCL_LAT, default 95, meaning the pair-issue to acceleration-valid latency in cycles (>=1).
REQ-003 SHALL have parameter ADD_LAT, default 20, meaning the adder latency in cycles (>=1).
REQ-004 SHALL have parameter STEP_W, default 16, meaning the timestep counter width.
REQ-005 SHALL have localparam BIDX_W = $clog2(BODIES).
REQ-006 SHALL have clk  in  1  clock; all logic on the rising edge.
REQ-007 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have go  in  1  run request; a rising edge starts a run, and low aborts.
REQ-009 SHALL have ack  in  1  software has read the results.
REQ-010 SHALL have cfg_last  in  BIDX_W  body count minus 1; legal range 1..BODIES-1; sampled at start.
REQ-011 SHALL have cfg_steps  in  STEP_W  timestep count minus 1; sampled at start.
REQ-012 SHALL have busy, done  out  1 each  a run is in progress / results are ready.
REQ-013 SHALL have phase  out  3  current FSM state encoding.
REQ-014 SHALL have pair_valid, pi_addr, pj_addr  out  1/BIDX_W/BIDX_W  the pair issued to the acceleration pipe.
REQ-015 SHALL have acc_first, acc_last  out  1 each  qualify the first and last issued pair of the row for body i.
REQ-016 SHALL have vwr_en, vwr_addr  out  1/BIDX_W  velocity accumulate write, ACCL_LAT cycles after its pair.
REQ-017 SHALL have upd_rd_en, upd_rd_addr, upd_wr_en, upd_wr_addr  out  position-update read, and the write ADD_LAT cycles later.
REQ-018 SHALL have step_cnt  out  STEP_W, and first_step  out  1, which is high during step 0 only (leapfrog half-kick).

Function
REQ-019 SHALL implement states IDLE, ACCEL, ACCEL_DRAIN, UPDATE, UPD_DRAIN, DONE.
REQ-020 SHALL leave IDLE for ACCEL on a registered rising edge of go while done=0; it latches cfg_* and clears step_cnt.
REQ-021 SHALL, in ACCEL, issue one pair per cycle in row-major order: i=0..cfg_last outer, j=0..cfg_last inner, with j wrapping to 0 and i incrementing.
REQ-022 SHALL, after the pair (cfg_last,cfg_last) is issued, go to ACCEL_DRAIN and stay there until the last vwr_en has fired.
REQ-023 SHALL, in UPDATE, assert upd_rd_en for addresses 0..cfg_last on consecutive cycles, then go to UPD_DRAIN until the last upd_wr_en has fired.
REQ-024 SHALL, at the end of UPD_DRAIN, go to DONE if step_cnt==cfg_steps; otherwise increment step_cnt and go to ACCEL.
REQ-025 SHALL hold done=1 in DONE until ack=1, then clear done and go to IDLE the next cycle; a new run requires a fresh go rising edge.
REQ-026 SHALL, when go=0 in any non-IDLE state, force IDLE next cycle, clear every delay-line valid bit, and emit no further enable pulses.
REQ-027 SHALL delay the write valid and address through shift registers, so that vwr_* equals pair_valid/pi_addr delayed exactly ACCL_LAT cycles and upd_wr_* equals upd_rd_* delayed exactly ADD_LAT cycles.
REQ-028 SHALL keep busy=1 in every state except IDLE and DONE.
REQ-029 SHALL keep the pair, rd, and wr enables at 0 outside their owning states and drains.
REQ-030 SHALL wrap step_cnt modulo 2^STEP_W without error.

Reset
REQ-031 SHALL, on rst, force state IDLE and zero all outputs, counters, latched config, and delay-line contents immediately, including mid-run.
REQ-032 SHALL, after rst deasserts with go already high, not start until go falls and rises again.

Configuration
REQ-033 SHALL, with NBODY_SKIP_SELF_EN defined, skip pairs where i==j entirely: each row has cfg_last issued pairs, acc_first/acc_last mark the first and last non-self j, and ACCEL lasts (cfg_last+1)*cfg_last cycles.
REQ-034 SHALL, without NBODY_SKIP_SELF_EN, issue all (cfg_last+1)^2 pairs, with self pairs flagged valid; downstream logic guards the divide-by-zero.

Structure
REQ-035 SHALL place the state enum type and the phase encoding constants in shared package nbody_pkg.
REQ-036 SHALL implement both delay lines with one sub-module, nbody_delay_line (parameters WIDTH and DEPTH, async reset, and a synchronous flush input).

Verification
REQ-037 SHALL verify a base run (BODIES=8, ACCL_LAT=5, ADD_LAT=3, cfg_last=2, cfg_steps=0, no macro) -> 9 pairs (0,0)..(2,2) on consecutive cycles; vwr_en for each pair exactly 5 cycles after it; 3 upd reads followed by writes 3 cycles later; done=1 until ack.
REQ-038 SHALL verify the same setup with NBODY_SKIP_SELF_EN -> 6 pairs (0,1),(0,2),(1,0),(1,2),(2,0),(2,1); acc_first on (0,1),(1,0),(2,0); acc_last on (0,2),(1,2),(2,1).
REQ-039 SHALL verify a multi-step run with cfg_steps=2 -> step_cnt 0,1,2; first_step high only during step 0; exactly one done pulse sequence after the third UPD_DRAIN.
REQ-040 SHALL verify an abort: go=0 on the 4th ACCEL cycle -> IDLE next cycle, busy=0, and zero vwr_en pulses for the following 10 cycles.
REQ-041 SHALL verify the handshake: go held high through ack -> IDLE with no restart; a go fall then rise -> a new run starts.
REQ-042 SHALL verify the minimum size, cfg_last=1 -> 4 pairs with correct j wrap; rst asserted during UPDATE -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared state type and phase encodings for the N-body pair/update sequencer.
package nbody_pkg;

  localparam logic [2:0] PH_IDLE        = 3'd0;
  localparam logic [2:0] PH_ACCEL       = 3'd1;
  localparam logic [2:0] PH_ACCEL_DRAIN = 3'd2;
  localparam logic [2:0] PH_UPDATE      = 3'd3;
  localparam logic [2:0] PH_UPD_DRAIN   = 3'd4;
  localparam logic [2:0] PH_DONE        = 3'd5;

  typedef enum logic [2:0] {
    IDLE        = PH_IDLE,
    ACCEL       = PH_ACCEL,
    ACCEL_DRAIN = PH_ACCEL_DRAIN,
    UPDATE      = PH_UPDATE,
    UPD_DRAIN   = PH_UPD_DRAIN,
    DONE        = PH_DONE
  } state_t;

endpackage

// File: rtl/nbody_delay_line.sv
// Fixed-latency shift register carrying {valid, address}; flush empties it in one cycle.
module nbody_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) sr_p[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) sr_p[k] <= '0;
    end else begin
      sr_p[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr_p[k] <= sr_p[k-1];
    end
  end

  assign dout = sr_p[DEPTH-1];

endmodule

// File: rtl/nbody_sequencer.sv
// Sequences all-pairs acceleration issue and position updates over several timesteps.
// Optional build macro NBODY_SKIP_SELF_EN drops the i==j pairs from the issue stream.
module nbody_sequencer
  import nbody_pkg::*;
#(
  parameter int BODIES   = 512,
  parameter int ACCL_LAT = 95,
  parameter int ADD_LAT  = 20,
  parameter int STEP_W   = 16,
  localparam int BIDX_W  = $clog2(BODIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              ack,
  input  logic [BIDX_W-1:0] cfg_last,
  input  logic [STEP_W-1:0] cfg_steps,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic              pair_valid,
  output logic [BIDX_W-1:0] pi_addr,
  output logic [BIDX_W-1:0] pj_addr,
  output logic              acc_first,
  output logic              acc_last,
  output logic              vwr_en,
  output logic [BIDX_W-1:0] vwr_addr,
  output logic              upd_rd_en,
  output logic [BIDX_W-1:0] upd_rd_addr,
  output logic              upd_wr_en,
  output logic [BIDX_W-1:0] upd_wr_addr,
  output logic [STEP_W-1:0] step_cnt,
  output logic              first_step
);

  localparam int MAX_LAT = (ACCL_LAT > ADD_LAT) ? ACCL_LAT : ADD_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0]  ACC_END = CNT_W'(ACCL_LAT - 1);
  localparam logic [CNT_W-1:0]  UPD_END = CNT_W'(ADD_LAT - 1);
  localparam logic [BIDX_W-1:0] ONE     = BIDX_W'(1);

  state_t state, state_nx;
  logic              go_q;
  logic [BIDX_W-1:0] last_q, i_cnt, j_cnt, j_first, j_step, j_start;
  logic [STEP_W-1:0] steps_q;
  logic [CNT_W-1:0]  dcnt;
  logic              start, abort, row_end, accel_end;
  logic [BIDX_W:0]   vline_out, uline_out;

  // go_q resets high so a go already asserted out of reset is not taken as an edge
  assign start = (state == IDLE) && go && !go_q;
  assign abort = (state != IDLE) && !go;

`ifdef NBODY_SKIP_SELF_EN
  assign j_start = ONE;
  assign j_first = (i_cnt == '0) ? ONE : '0;
  assign row_end = (j_cnt == last_q) || ((j_cnt == last_q - ONE) && (i_cnt == last_q));
  assign j_step  = (j_cnt + ONE == i_cnt) ? j_cnt + BIDX_W'(2) : j_cnt + ONE;
`else
  assign j_start = '0;
  assign j_first = '0;
  assign row_end = (j_cnt == last_q);
  assign j_step  = j_cnt + ONE;
`endif

  assign accel_end = row_end && (i_cnt == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (start) state_nx = ACCEL;
      ACCEL:       if (accel_end) state_nx = ACCEL_DRAIN;
      ACCEL_DRAIN: if (dcnt == ACC_END) state_nx = UPDATE;
      UPDATE:      if (i_cnt == last_q) state_nx = UPD_DRAIN;
      UPD_DRAIN:   if (dcnt == UPD_END) state_nx = (step_cnt == steps_q) ? DONE : ACCEL;
      DONE:        if (ack) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q     <= 1'b1;
      last_q   <= '0;
      steps_q  <= '0;
      step_cnt <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      dcnt     <= '0;
    end else begin
      go_q <= go;
      dcnt <= ((state == ACCEL_DRAIN || state == UPD_DRAIN) && state_nx == state) ? dcnt + CNT_W'(1) : '0;
      case (state)
        IDLE: if (start) begin
          last_q   <= cfg_last;
          steps_q  <= cfg_steps;
          step_cnt <= '0;
          i_cnt    <= '0;
          j_cnt    <= j_start;
        end
        ACCEL: begin
          if (accel_end) begin
            i_cnt <= '0;
          end else if (row_end) begin
            i_cnt <= i_cnt + ONE;
            j_cnt <= '0;
          end else begin
            j_cnt <= j_step;
          end
        end
        UPDATE: i_cnt <= i_cnt + ONE;
        UPD_DRAIN: if (state_nx == ACCEL) begin
          step_cnt <= step_cnt + STEP_W'(1);
          i_cnt    <= '0;
          j_cnt    <= j_start;
        end
        default: ;
      endcase
    end
  end

  // Issue stage: enables are gated by go so an abort cycle emits nothing
  assign pair_valid  = (state == ACCEL) && go;
  assign pi_addr     = i_cnt;
  assign pj_addr     = j_cnt;
  assign acc_first   = pair_valid && (j_cnt == j_first);
  assign acc_last    = pair_valid && row_end;
  assign upd_rd_en   = (state == UPDATE) && go;
  assign upd_rd_addr = i_cnt;

  nbody_delay_line #(.WIDTH(BIDX_W + 1), .DEPTH(ACCL_LAT)) u_vline (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   ({pair_valid, pi_addr}),
    .dout  (vline_out)
  );

  nbody_delay_line #(.WIDTH(BIDX_W + 1), .DEPTH(ADD_LAT)) u_uline (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   ({upd_rd_en, upd_rd_addr}),
    .dout  (uline_out)
  );

  // Write stage: delayed copies of the issue stage
  assign vwr_en      = vline_out[BIDX_W] && !abort;
  assign vwr_addr    = vline_out[BIDX_W-1:0];
  assign upd_wr_en   = uline_out[BIDX_W] && !abort;
  assign upd_wr_addr = uline_out[BIDX_W-1:0];

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign phase      = state;
  assign first_step = busy && (step_cnt == '0);

endmodule

// File: tb/tb_nbody_sequencer.sv
// Directed bench for nbody_sequencer: base, multi-step, abort, handshake, minimum size, reset.
module tb_nbody_sequencer;
  import nbody_pkg::*;

  localparam int BODIES = 8, ACCL_LAT = 5, ADD_LAT = 3, STEP_W = 16, BIDX_W = 3;
`ifdef NBODY_SKIP_SELF_EN
  localparam int NPS = 6;
`else
  localparam int NPS = 9;
`endif

  logic clk = 1'b0;
  logic rst, go, ack;
  logic [BIDX_W-1:0] cfg_last;
  logic [STEP_W-1:0] cfg_steps;
  logic busy, done, pair_valid, acc_first, acc_last, vwr_en, upd_rd_en, upd_wr_en, first_step;
  logic [2:0] phase;
  logic [BIDX_W-1:0] pi_addr, pj_addr, vwr_addr, upd_rd_addr, upd_wr_addr;
  logic [STEP_W-1:0] step_cnt;

  nbody_sequencer #(.BODIES(BODIES), .ACCL_LAT(ACCL_LAT), .ADD_LAT(ADD_LAT), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .go(go), .ack(ack), .cfg_last(cfg_last), .cfg_steps(cfg_steps),
    .busy(busy), .done(done), .phase(phase), .pair_valid(pair_valid), .pi_addr(pi_addr),
    .pj_addr(pj_addr), .acc_first(acc_first), .acc_last(acc_last), .vwr_en(vwr_en),
    .vwr_addr(vwr_addr), .upd_rd_en(upd_rd_en), .upd_rd_addr(upd_rd_addr),
    .upd_wr_en(upd_wr_en), .upd_wr_addr(upd_wr_addr), .step_cnt(step_cnt), .first_step(first_step)
  );

  always #5 clk = ~clk;

  typedef struct {int c; int i; int j; int f; int l; int s; int fs;} pair_t;
  pair_t pq[$];
  pair_t tmp;
  int vc[$], va[$], rc[$], ra[$], wc[$], wa[$];
  int exp_i[$], exp_j[$], exp_f[$], exp_l[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, done_rises = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pair_valid) begin
      tmp.c = cyc; tmp.i = int'(pi_addr); tmp.j = int'(pj_addr);
      tmp.f = int'(acc_first); tmp.l = int'(acc_last);
      tmp.s = int'(step_cnt); tmp.fs = int'(first_step);
      pq.push_back(tmp);
    end
    if (vwr_en)    begin vc.push_back(cyc); va.push_back(int'(vwr_addr)); end
    if (upd_rd_en) begin rc.push_back(cyc); ra.push_back(int'(upd_rd_addr)); end
    if (upd_wr_en) begin wc.push_back(cyc); wa.push_back(int'(upd_wr_addr)); end
    if (done && !done_q) done_rises++;
    done_q = done;
  end

  task automatic chk(input string tag, input longint got, input longint expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    pq.delete(); vc.delete(); va.delete(); rc.delete(); ra.delete(); wc.delete(); wa.delete();
  endtask

  task automatic start_run(input int l, input int s);
    cfg_last  = BIDX_W'(l);
    cfg_steps = STEP_W'(s);
    go = 1'b0;
    tick();
    clr_logs();
    go = 1'b1;
    tick();
    chk("start_phase", phase, PH_ACCEL);
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] ph, input int budget);
    int n = 0;
    while (phase != ph && n < budget) begin
      tick();
      n++;
    end
    chk(tag, phase, ph);
  endtask

  task automatic check_pairs(input string tag);
    chk({tag, "_npairs"}, pq.size(), exp_i.size());
    for (int k = 0; k < pq.size() && k < exp_i.size(); k++) begin
      chk({tag, "_pi"}, pq[k].i, exp_i[k]);
      chk({tag, "_pj"}, pq[k].j, exp_j[k]);
      chk({tag, "_first"}, pq[k].f, exp_f[k]);
      chk({tag, "_last"}, pq[k].l, exp_l[k]);
      if (k > 0) chk({tag, "_pair_gap"}, pq[k].c - pq[k-1].c, 1);
    end
  endtask

  task automatic check_vwr_upd(input string tag, input int nrd);
    chk({tag, "_nvwr"}, vc.size(), pq.size());
    for (int k = 0; k < vc.size() && k < pq.size(); k++) begin
      chk({tag, "_vwr_lat"}, vc[k] - pq[k].c, ACCL_LAT);
      chk({tag, "_vwr_addr"}, va[k], pq[k].i);
    end
    chk({tag, "_nrd"}, rc.size(), nrd);
    chk({tag, "_nwr"}, wc.size(), nrd);
    for (int k = 0; k < rc.size() && k < wc.size(); k++) begin
      chk({tag, "_rd_addr"}, ra[k], k);
      chk({tag, "_wr_lat"}, wc[k] - rc[k], ADD_LAT);
      chk({tag, "_wr_addr"}, wa[k], ra[k]);
    end
    if (rc.size() > 0 && vc.size() > 0) chk({tag, "_rd_after_vwr"}, rc[0] - vc[vc.size()-1], 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b1; ack = 1'b0; cfg_last = '0; cfg_steps = '0;
    tick(); tick();
    chk("rst_phase", phase, PH_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_vwr_en", vwr_en, 0);
    chk("rst_step_cnt", step_cnt, 0);

    // go held high across reset release must not start a run
    rst = 1'b0;
    repeat (5) tick();
    chk("no_start_after_rst", phase, PH_IDLE);

`ifdef NBODY_SKIP_SELF_EN
    exp_i = '{0,0,1,1,2,2}; exp_j = '{1,2,0,2,0,1};
    exp_f = '{1,0,1,0,1,0}; exp_l = '{0,1,0,1,0,1};
`else
    exp_i = '{0,0,0,1,1,1,2,2,2}; exp_j = '{0,1,2,0,1,2,0,1,2};
    exp_f = '{1,0,0,1,0,0,1,0,0}; exp_l = '{0,0,1,0,0,1,0,0,1};
`endif
    start_run(2, 0);
    chk("base_busy", busy, 1);
    chk("base_first_step", first_step, 1);
    wait_phase("base_reach_done", PH_DONE, 100);
    check_pairs("base");
    check_vwr_upd("base", 3);
    repeat (3) begin
      tick();
      chk("done_hold", done, 1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle", phase, PH_IDLE);
    chk("ack_done_clear", done, 0);
    repeat (5) tick();
    chk("no_restart_phase", phase, PH_IDLE);
    chk("no_restart_busy", busy, 0);

    // multi-step run, also the fresh-edge restart
    done_rises = 0;
    start_run(2, 2);
    wait_phase("multi_reach_done", PH_DONE, 300);
    repeat (5) tick();
    chk("multi_done_rises", done_rises, 1);
    chk("multi_step_final", step_cnt, 2);
    chk("multi_npairs", pq.size(), 3 * NPS);
    chk("multi_nrd", rc.size(), 9);
    if (pq.size() == 3 * NPS) begin
      chk("multi_step0", pq[0].s, 0);
      chk("multi_fs0", pq[0].fs, 1);
      chk("multi_fs0_end", pq[NPS-1].fs, 1);
      chk("multi_step1", pq[NPS].s, 1);
      chk("multi_fs1", pq[NPS].fs, 0);
      chk("multi_step2", pq[2*NPS].s, 2);
      chk("multi_fs2", pq[2*NPS].fs, 0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("multi_ack_idle", phase, PH_IDLE);

    // abort on the 4th ACCEL cycle
    start_run(2, 0);
    repeat (3) tick();
    chk("abort_pre_phase", phase, PH_ACCEL);
    go = 1'b0;
    tick();
    chk("abort_phase", phase, PH_IDLE);
    chk("abort_busy", busy, 0);
    vc.delete();
    repeat (10) tick();
    chk("abort_vwr_pulses", vc.size(), 0);

    // minimum size, then reset in UPDATE
`ifdef NBODY_SKIP_SELF_EN
    exp_i = '{0,1}; exp_j = '{1,0}; exp_f = '{1,1}; exp_l = '{1,1};
`else
    exp_i = '{0,0,1,1}; exp_j = '{0,1,0,1}; exp_f = '{1,0,1,0}; exp_l = '{0,1,0,1};
`endif
    start_run(1, 0);
    wait_phase("min_reach_update", PH_UPDATE, 50);
    check_pairs("min");
    chk("min_rd_en_before_rst", upd_rd_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_phase", phase, PH_IDLE);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_pair_valid", pair_valid, 0);
    chk("rstmid_upd_rd_en", upd_rd_en, 0);
    chk("rstmid_upd_rd_addr", upd_rd_addr, 0);
    chk("rstmid_upd_wr_en", upd_wr_en, 0);
    chk("rstmid_vwr_en", vwr_en, 0);
    chk("rstmid_step_cnt", step_cnt, 0);
    chk("rstmid_first_step", first_step, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_idle", phase, PH_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
